// File: rtl/arb2_rr.sv
// Round-robin selector for two requesters with a bounded burst.
// Holds the owner/burst-count/tie-priority state and produces the
// combinational grant (accept + sel) for the current cycle.
module arb2_rr #(
  parameter int MAXBURST = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req0,
  input  logic req1,
  output logic accept,
  output logic sel
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] OWN0  = 2'd1;
  localparam logic [1:0] OWN1  = 2'd2;
  localparam logic [3:0] LIMIT = 4'(MAXBURST);

  logic [1:0] own_reg;
  logic [3:0] cnt_reg;
  logic       pri_reg;
  logic       acc_next;
  logic       sel_next;
  logic [1:0] sel_own;

  // Grant selection: the owner keeps the port until its burst is spent
  // while the peer waits; from IDLE a tie goes to the favoured requester.
  always_comb begin
    acc_next = 1'b0;
    sel_next = 1'b0;
    case (own_reg)
      OWN0: begin
        if (req0 && ((cnt_reg < LIMIT) || !req1)) begin
          acc_next = 1'b1;
          sel_next = 1'b0;
        end else if (req1) begin
          acc_next = 1'b1;
          sel_next = 1'b1;
        end
      end
      OWN1: begin
        if (req1 && ((cnt_reg < LIMIT) || !req0)) begin
          acc_next = 1'b1;
          sel_next = 1'b1;
        end else if (req0) begin
          acc_next = 1'b1;
          sel_next = 1'b0;
        end
      end
      default: begin
        if (req0 && req1) begin
          acc_next = 1'b1;
          sel_next = pri_reg;
        end else if (req0) begin
          acc_next = 1'b1;
          sel_next = 1'b0;
        end else if (req1) begin
          acc_next = 1'b1;
          sel_next = 1'b1;
        end
      end
    endcase
  end

  // Nothing is granted while reset is held, so no write can slip through.
  assign accept  = acc_next & ~rst_i;
  assign sel     = sel_next;
  assign sel_own = sel_next ? OWN1 : OWN0;

  // Owner, burst count and tie priority advance on every granted cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      own_reg <= IDLE;
      cnt_reg <= 4'd0;
      pri_reg <= 1'b0;
    end else if (acc_next) begin
      own_reg <= sel_own;
      pri_reg <= ~sel_next;
      if (own_reg == sel_own) begin
        // Past the limit the owner only continues when uncontended,
        // which starts a fresh burst.
        cnt_reg <= (cnt_reg < LIMIT) ? cnt_reg + 4'd1 : 4'd1;
      end else begin
        cnt_reg <= 4'd1;
      end
    end else begin
      own_reg <= IDLE;
      cnt_reg <= 4'd0;
    end
  end

endmodule

// File: rtl/ram_port_arb2.sv
// Shares the read/write port of the 1W/2R RAM between two bus masters.
// Muxes the granted request onto the RAM port and returns registered
// read data with a one-cycle valid pulse per requester.
module ram_port_arb2 #(
  parameter  int SZ       = 2,
  parameter  int DW       = 32,
  parameter  int MAXBURST = 4,
  localparam int AW       = (SZ > 1) ? $clog2(SZ) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  input  logic [AW-1:0] m0_addr_i,
  input  logic [DW-1:0] m0_data_i,
  output logic          m0_rdy_o,
  output logic          m0_val_o,
  output logic [DW-1:0] m0_data_o,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  input  logic [AW-1:0] m1_addr_i,
  input  logic [DW-1:0] m1_data_i,
  output logic          m1_rdy_o,
  output logic          m1_val_o,
  output logic [DW-1:0] m1_data_o,
  output logic          ram_we_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [DW-1:0] ram_data_o,
  input  logic [DW-1:0] ram_data_i
);

  logic          accept;
  logic          sel;
  logic [1:0]    rdy;
  logic [1:0]    we_in;
  logic [1:0]    rd_fire;
  logic [1:0]    val_reg;
  logic [DW-1:0] rdata_reg [2];

  arb2_rr #(
    .MAXBURST(MAXBURST)
  ) u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req0  (m0_stb_i),
    .req1  (m1_stb_i),
    .accept(accept),
    .sel   (sel)
  );

  assign rdy[0]   = accept & ~sel;
  assign rdy[1]   = accept & sel;
  assign we_in[0] = m0_we_i;
  assign we_in[1] = m1_we_i;
  assign m0_rdy_o = rdy[0];
  assign m1_rdy_o = rdy[1];

  // With no grant the address defaults to requester 0 and we stays low.
  assign ram_addr_o = rdy[1] ? m1_addr_i : m0_addr_i;
  assign ram_data_o = rdy[1] ? m1_data_i : m0_data_i;
  assign ram_we_o   = accept & (sel ? m1_we_i : m0_we_i);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ret
      assign rd_fire[gi] = rdy[gi] & ~we_in[gi];

      // Capture RAM read data one edge after a granted read; the data
      // register holds until that requester's next read completes.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          val_reg[gi]   <= 1'b0;
          rdata_reg[gi] <= '0;
        end else begin
          val_reg[gi] <= rd_fire[gi];
          if (rd_fire[gi]) begin
            rdata_reg[gi] <= ram_data_i;
          end
        end
      end
    end
  endgenerate

  assign m0_val_o  = val_reg[0];
  assign m1_val_o  = val_reg[1];
  assign m0_data_o = rdata_reg[0];
  assign m1_data_o = rdata_reg[1];

endmodule

// File: tb/tb_ram_port_arb2.sv
// Bench for ram_port_arb2: directed scenarios plus a randomized run
// checked against a streak/last-grant reference model.
module tb_ram_port_arb2;

  localparam int SZ = 16;
  localparam int DW = 32;
  localparam int MB = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          m0_stb_i, m0_we_i, m1_stb_i, m1_we_i;
  logic [3:0]    m0_addr_i, m1_addr_i;
  logic [DW-1:0] m0_data_i, m1_data_i;
  logic          m0_rdy_o, m0_val_o, m1_rdy_o, m1_val_o;
  logic [DW-1:0] m0_data_o, m1_data_o;
  logic          ram_we_o;
  logic [3:0]    ram_addr_o;
  logic [DW-1:0] ram_data_o, ram_data_i;

  int errors = 0;
  int checks = 0;

  // Bench-side RAM: combinational read, write on the clock edge.
  logic [DW-1:0] ram [SZ];
  logic          clr_ram;

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (clr_ram) begin
      for (int i = 0; i < SZ; i++) ram[i] <= 32'hC0DE_0000 | 32'(i);
    end else if (ram_we_o) begin
      ram[ram_addr_o] <= ram_data_o;
    end
  end
  assign ram_data_i = ram[ram_addr_o];

  ram_port_arb2 #(.SZ(SZ), .DW(DW), .MAXBURST(MB)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i),
    .m0_rdy_o(m0_rdy_o), .m0_val_o(m0_val_o), .m0_data_o(m0_data_o),
    .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i),
    .m1_rdy_o(m1_rdy_o), .m1_val_o(m1_val_o), .m1_data_o(m1_data_o),
    .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o),
    .ram_data_i(ram_data_i)
  );

  task automatic idle_all();
    m0_stb_i = 0; m0_we_i = 0; m0_addr_i = 0; m0_data_i = 0;
    m1_stb_i = 0; m1_we_i = 0; m1_addr_i = 0; m1_data_i = 0;
  endtask

  // Full reset; also refills the bench RAM with a known pattern.
  task automatic do_reset();
    idle_all();
    rst_i = 1; clr_ram = 1;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 0; clr_ram = 0;
  endtask

  task automatic test_reset();
    do_reset();
    // Preload @5 with a known word.
    m0_stb_i = 1; m0_we_i = 1; m0_addr_i = 5; m0_data_i = 32'hAAAA_AAAA;
    #1; checks++;
    if (m0_rdy_o !== 1'b1) begin errors++; $display("FAIL rst_preload_rdy: got %b want 1", m0_rdy_o); end
    @(negedge clk_i);
    // Write pending, then reset asserted mid-cycle.
    m0_data_i = 32'h1111_1111;
    #1; checks++;
    if (ram_we_o !== 1'b1) begin errors++; $display("FAIL rst_we_before: got %b want 1", ram_we_o); end
    #1 rst_i = 1;
    #1; checks++;
    if (ram_we_o !== 1'b0) begin errors++; $display("FAIL rst_we_async: got %b want 0", ram_we_o); end
    checks++;
    if (m0_rdy_o !== 1'b0) begin errors++; $display("FAIL rst_rdy_async: got %b want 0", m0_rdy_o); end
    @(negedge clk_i);
    rst_i = 0; idle_all();
    #1; checks++;
    if ({m0_val_o, m1_val_o} !== 2'b00) begin errors++; $display("FAIL rst_val: got %b want 00", {m0_val_o, m1_val_o}); end
    checks++;
    if (m0_data_o !== 32'h0 || m1_data_o !== 32'h0) begin
      errors++; $display("FAIL rst_data: got %h/%h want 0/0", m0_data_o, m1_data_o);
    end
    $display("reset: blocked write @5 under reset");
    // Read @5: the blocked write must not have landed.
    @(negedge clk_i);
    m0_stb_i = 1; m0_we_i = 0; m0_addr_i = 5;
    #1; checks++;
    if (m0_rdy_o !== 1'b1) begin errors++; $display("FAIL rst_read_rdy: got %b want 1", m0_rdy_o); end
    @(posedge clk_i);
    #1; m0_stb_i = 0; checks++;
    if (m0_val_o !== 1'b1 || m0_data_o !== 32'hAAAA_AAAA) begin
      errors++; $display("FAIL rst_read_back: got val=%b data=%h want 1/aaaaaaaa", m0_val_o, m0_data_o);
    end
    // Reset during the val pulse clears it at once.
    rst_i = 1;
    #1; checks++;
    if (m0_val_o !== 1'b0) begin errors++; $display("FAIL rst_mid_read_val: got %b want 0", m0_val_o); end
    @(negedge clk_i);
    rst_i = 0;
    $display("reset: read @5 then reset during val pulse");
  endtask

  task automatic test_single();
    do_reset();
    m0_stb_i = 1; m0_we_i = 1; m0_addr_i = 3; m0_data_i = 32'hDEAD_BEEF;
    #1; checks++;
    if (m0_rdy_o !== 1'b1 || ram_we_o !== 1'b1 || ram_addr_o !== 4'd3 || ram_data_o !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL single_write: got rdy=%b we=%b addr=%0d data=%h want 1/1/3/deadbeef",
                         m0_rdy_o, ram_we_o, ram_addr_o, ram_data_o);
    end
    $display("single: m0 write @3 = deadbeef");
    @(negedge clk_i);
    m0_we_i = 0;
    #1; checks++;
    if (m0_rdy_o !== 1'b1 || ram_we_o !== 1'b0) begin
      errors++; $display("FAIL single_read_acc: got rdy=%b we=%b want 1/0", m0_rdy_o, ram_we_o);
    end
    checks++;
    if (m0_val_o !== 1'b0) begin errors++; $display("FAIL single_write_noval: got %b want 0", m0_val_o); end
    $display("single: m0 read @3");
    @(negedge clk_i);
    m0_stb_i = 0;
    #1; checks++;
    if (m0_val_o !== 1'b1 || m0_data_o !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL single_read_data: got val=%b data=%h want 1/deadbeef", m0_val_o, m0_data_o);
    end
    @(negedge clk_i);
    #1; checks++;
    if (m0_val_o !== 1'b0 || m0_data_o !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL single_hold: got val=%b data=%h want 0/deadbeef", m0_val_o, m0_data_o);
    end
  endtask

  task automatic test_tie();
    do_reset();
    m0_stb_i = 1; m0_addr_i = 0; m1_stb_i = 1; m1_addr_i = 1;
    #1; checks++;
    if ({m0_rdy_o, m1_rdy_o} !== 2'b10 || ram_addr_o !== 4'd0) begin
      errors++; $display("FAIL tie_first: got rdy=%b%b addr=%0d want 10/0", m0_rdy_o, m1_rdy_o, ram_addr_o);
    end
    @(negedge clk_i);
    m0_stb_i = 0;
    #1; checks++;
    if ({m0_rdy_o, m1_rdy_o} !== 2'b01 || ram_addr_o !== 4'd1) begin
      errors++; $display("FAIL tie_second: got rdy=%b%b addr=%0d want 01/1", m0_rdy_o, m1_rdy_o, ram_addr_o);
    end
    checks++;
    if (m0_val_o !== 1'b1 || m1_val_o !== 1'b0 || m0_data_o !== 32'hC0DE_0000) begin
      errors++; $display("FAIL tie_val0: got val=%b%b data=%h want 10/c0de0000", m0_val_o, m1_val_o, m0_data_o);
    end
    @(negedge clk_i);
    m1_stb_i = 0;
    #1; checks++;
    if (m1_val_o !== 1'b1 || m0_val_o !== 1'b0 || m1_data_o !== 32'hC0DE_0001) begin
      errors++; $display("FAIL tie_val1: got val=%b%b data=%h want 01/c0de0001", m0_val_o, m1_val_o, m1_data_o);
    end
    $display("tie: m0 @0 then m1 @1");
  endtask

  task automatic test_burst();
    int pat [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    do_reset();
    m0_stb_i = 1; m0_addr_i = 2; m1_stb_i = 1; m1_addr_i = 7;
    for (int k = 0; k < 10; k++) begin
      #1; checks++;
      if (m0_rdy_o !== (pat[k] == 0) || m1_rdy_o !== (pat[k] == 1)) begin
        errors++; $display("FAIL burst_cycle%0d: got rdy=%b%b want owner %0d", k, m0_rdy_o, m1_rdy_o, pat[k]);
      end
      $display("burst: cycle %0d grant m%0d", k, m1_rdy_o);
      @(negedge clk_i);
    end
    idle_all();
  endtask

  task automatic test_no_contention();
    do_reset();
    m1_stb_i = 1; m1_we_i = 0;
    for (int k = 0; k < 11; k++) begin
      m1_stb_i = (k < 10);
      m1_addr_i = 4'(k);
      #1;
      if (k < 10) begin
        checks++;
        if (m1_rdy_o !== 1'b1) begin errors++; $display("FAIL solo_rdy%0d: got %b want 1", k, m1_rdy_o); end
      end
      if (k > 0) begin
        checks++;
        if (m1_val_o !== 1'b1 || m1_data_o !== (32'hC0DE_0000 | 32'(k - 1))) begin
          errors++; $display("FAIL solo_val%0d: got val=%b data=%h want 1/%h", k, m1_val_o, m1_data_o,
                             32'hC0DE_0000 | 32'(k - 1));
        end
      end
      $display("solo: m1 cycle %0d rdy=%b", k, m1_rdy_o);
      @(negedge clk_i);
    end
    idle_all();
  endtask

  task automatic test_raw();
    do_reset();
    m0_stb_i = 1; m0_we_i = 1; m0_addr_i = 1; m0_data_i = 32'h5A;
    @(negedge clk_i);
    m0_stb_i = 0; m1_stb_i = 1; m1_we_i = 0; m1_addr_i = 1;
    #1; checks++;
    if (m1_rdy_o !== 1'b1) begin errors++; $display("FAIL raw_rdy: got %b want 1", m1_rdy_o); end
    @(negedge clk_i);
    m1_stb_i = 0;
    #1; checks++;
    if (m1_val_o !== 1'b1 || m1_data_o !== 32'h5A) begin
      errors++; $display("FAIL raw_data: got val=%b data=%h want 1/0000005a", m1_val_o, m1_data_o);
    end
    $display("raw: m0 write @1 then m1 read @1");
  endtask

  // Reference model: the grant goes to the requester that most recently won
  // while its streak is unfinished; otherwise to the other one.
  task automatic test_random();
    int            last_grant, streak, g;
    logic [DW-1:0] mem_m [SZ];
    logic          ev0, ev1, p0, p1, w0, w1, gw;
    logic [DW-1:0] ed0, ed1, d0, d1, gd;
    logic [3:0]    a0, a1, ga;
    do_reset();
    last_grant = 1; streak = 0;
    ev0 = 0; ev1 = 0; ed0 = 0; ed1 = 0;
    p0 = 0; p1 = 0; w0 = 0; w1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0;
    for (int i = 0; i < SZ; i++) mem_m[i] = 32'hC0DE_0000 | 32'(i);
    for (int c = 0; c < 400; c++) begin
      if (!p0 && $urandom_range(3) != 0) begin
        p0 = 1; w0 = 1'($urandom_range(1)); a0 = 4'($urandom_range(15)); d0 = $urandom;
      end
      if (!p1 && $urandom_range(3) != 0) begin
        p1 = 1; w1 = 1'($urandom_range(1)); a1 = 4'($urandom_range(15)); d1 = $urandom;
      end
      m0_stb_i = p0; m0_we_i = w0; m0_addr_i = a0; m0_data_i = d0;
      m1_stb_i = p1; m1_we_i = w1; m1_addr_i = a1; m1_data_i = d1;
      #1;
      if (p0 && p1) g = (streak > 0 && streak < MB) ? last_grant : 1 - last_grant;
      else if (p0)  g = 0;
      else if (p1)  g = 1;
      else          g = -1;
      gw = (g == 1) ? w1 : (g == 0) ? w0 : 1'b0;
      ga = (g == 1) ? a1 : a0;
      gd = (g == 1) ? d1 : d0;
      checks++;
      if (m0_rdy_o !== (g == 0) || m1_rdy_o !== (g == 1)) begin
        errors++; $display("FAIL rand_rdy c%0d: got %b%b want grant %0d", c, m0_rdy_o, m1_rdy_o, g);
      end
      checks++;
      if (ram_we_o !== gw || ram_addr_o !== ga || (gw && ram_data_o !== gd)) begin
        errors++; $display("FAIL rand_port c%0d: got we=%b addr=%0d data=%h want %b/%0d/%h",
                           c, ram_we_o, ram_addr_o, ram_data_o, gw, ga, gd);
      end
      checks++;
      if (m0_val_o !== ev0 || m1_val_o !== ev1 || m0_data_o !== ed0 || m1_data_o !== ed1) begin
        errors++; $display("FAIL rand_ret c%0d: got %b %h %b %h want %b %h %b %h",
                           c, m0_val_o, m0_data_o, m1_val_o, m1_data_o, ev0, ed0, ev1, ed1);
      end
      if (g >= 0) begin
        if (streak > 0 && g == last_grant) streak = (streak >= MB) ? 1 : streak + 1;
        else streak = 1;
        last_grant = g;
        ev0 = (g == 0) && !gw;
        ev1 = (g == 1) && !gw;
        if (gw) mem_m[ga] = gd;
        else if (g == 0) ed0 = mem_m[ga];
        else ed1 = mem_m[ga];
        if (g == 0) p0 = 0; else p1 = 0;
        $display("rand: c%0d m%0d %s @%0d", c, g, gw ? "wr" : "rd", ga);
      end else begin
        streak = 0; ev0 = 0; ev1 = 0;
      end
      @(negedge clk_i);
    end
    idle_all();
  endtask

  initial begin
    rst_i = 1; clr_ram = 1;
    idle_all();
    @(negedge clk_i);
    test_reset();
    test_single();
    test_tie();
    test_burst();
    test_no_contention();
    test_raw();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_port_arb2.md
Name: ram_port_arb2

Overview:
- Two-requester arbiter sharing the single read/write port (port 1: we, addr, data-in, data-out) of the team's 1-write/2-read RAM.
- Port 0, the read-only port, stays outside this block.
- Round-robin with a bounded burst: an owner keeps the port for up to MAXBURST consecutive accepted cycles, then yields to a waiting peer.
- Read data is registered, with a per-requester valid pulse. Sits between two bus masters (e.g. a CPU load/store unit and a DMA/loader) and the RAM.

Parameters:
- SZ, 2, RAM depth in words; address width AW = clog2(SZ).
- DW, 32, data width.
- MAXBURST, 4, max consecutive accepts by one owner while the other requests; legal range 1..15.

Ports:
- clk_i  in  1  clock; all state on posedge.
- rst_i  in  1  asynchronous, active-high reset.
- m0_stb_i  in  1  requester 0 request strobe; held until accepted.
- m0_we_i  in  1  1 = write, 0 = read.
- m0_addr_i  in  AW  word address.
- m0_data_i  in  DW  write data.
- m0_rdy_o  out  1  combinational; request accepted this cycle.
- m0_val_o  out  1  registered; read data valid (one cycle after accepted read).
- m0_data_o  out  DW  registered read data.
- m1_stb_i, m1_we_i, m1_addr_i, m1_data_i, m1_rdy_o, m1_val_o, m1_data_o: same as m0, for requester 1.
- ram_we_o  out  1  to RAM we1.
- ram_addr_o  out  AW  to RAM addr1.
- ram_data_o  out  DW  to RAM i1.
- ram_data_i  in  DW  from RAM o1 (combinational read).

Behaviour:
- State: own ∈ {IDLE, OWN0, OWN1}; cnt (4b); pri (1b, requester favoured in IDLE ties).
- Reset (async, rst_i high): own = IDLE, cnt = 0, pri = 0, m*_val_o = 0, m*_data_o = 0.
- While rst_i is high, all rdy_o = 0 and ram_we_o = 0, so no write reaches the RAM.
- Selection, combinational, each cycle:
  - IDLE: both stb → sel = pri; one stb → that one; none → no accept.
  - OWNx: mx_stb and (cnt < MAXBURST or other not requesting) → sel = x. Otherwise other requesting → sel = other. Otherwise no accept.
- Accept: m<sel>_rdy_o = 1; the other rdy_o = 0; at most one rdy_o per cycle.
- RAM muxing: ram_addr_o / ram_data_o come from sel. ram_we_o = sel_we & accept.
- With no accept, ram_addr_o holds m0_addr_i and ram_we_o = 0.
- Next state on accept:
  - own ← OWN<sel>; pri ← ~sel.
  - cnt ← (sel == previous owner) ? min(cnt+1, 15) : 1.
  - If own owner continues past the limit with no contention, cnt ← 1 (fresh burst).
- No accept: own ← IDLE, cnt ← 0, pri unchanged.
- Read latency: an accepted read at cycle N latches ram_data_i into m<sel>_data_o at edge N+1 and pulses m<sel>_val_o for exactly one cycle.
- Writes produce no val pulse. m*_data_o holds its value until the next read completes for that requester.
- Back-to-back reads from one requester give val high on consecutive cycles.
- Read-after-write to the same address in consecutive cycles returns the new data (the RAM write lands at edge N).
- MAXBURST = 1 under constant contention gives strict alternation 0,1,0,1…
- Requester dropping stb mid-burst: the peer is granted the same cycle if requesting; otherwise IDLE.
- Reset asserted mid-read: the pending val pulse is suppressed.

Decomposition:
- Use the shared lib/clog2.v include for AW.
- State encoding (IDLE = 0, OWN0 = 1, OWN1 = 2) as localparams in the module; no package needed.
- One natural sub-module: arb2_rr. It holds the own/cnt/pri state and the selection logic and outputs sel/accept. ram_port_arb2 adds the muxing and read-return registers.

Test Plan:
- Reset: assert rst_i async mid-cycle with m0 write pending → ram_we_o = 0 immediately; after release, all val = 0, own = IDLE.
- Single requester: m0 writes 0xDEADBEEF @3, then reads @3 → rdy same cycle; m0_val_o pulses one cycle later with m0_data_o = 0xDEADBEEF.
- Tie from IDLE after reset: both stb, reads @0 / @1 → m0 accepted first (pri = 0), m1 next cycle; val pulses on m0 then m1.
- Burst limit: MAXBURST = 4, both continuously requesting → accept pattern 0,0,0,0,1,1,1,1,0…
- No contention: m1 alone for 10 cycles → 10 consecutive accepts, cnt never blocks.
- Read-after-write: m0 writes 0x5A @1 at cycle N, m1 reads @1 at N+1 → m1_data_o = 0x5A at N+2.
